// File: rtl/mem_pkg.sv
// Shared constants and types for the port-B memory arbiter.
// The debug struct exposes the FSM state and the round-robin pointer.
package mem_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  typedef logic req_id_t;

  typedef struct packed {
    state_e  state;
    req_id_t rr_last;
  } dbg_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time wins.
module rr_arb2
  import mem_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  req_id_t last,
  output req_id_t winner,
  output logic    valid
);

  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares RAM port B between two requesters with round-robin priority.
// Handshake: reqN/weN/addrN/wdataN held until gntN pulses; rvalidN pulses once per read, 2 cycles after gntN.
module mem_port_arbiter #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DEPTH  = mem_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output mem_pkg::dbg_t     dbg
);

  import mem_pkg::*;

  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  state_e  state, state_n;
  req_id_t rr_last, rr_last_n;
  req_id_t pend_id, pend_id_n;
  logic    pend_we, pend_we_n;
  logic    pend_err, pend_err_n;

  logic gnt0_n, gnt1_n, rvalid0_n, rvalid1_n, err0_n, err1_n, ram_en_n;
  logic [ADDR_W-1:0] ram_addr_n;
  logic [DATA_W-1:0] ram_wdata_n, rdata0_n, rdata1_n;

  req_id_t           winner;
  logic              any_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic [DATA_W-1:0] cap_data;

  rr_arb2 u_arb (
    .req0   (req0),
    .req1   (req1),
    .last   (rr_last),
    .winner (winner),
    .valid  (any_req)
  );

  assign sel_we    = winner ? we1 : we0;
  assign sel_addr  = winner ? addr1 : addr0;
  assign sel_wdata = winner ? wdata1 : wdata0;
  assign in_range  = ({1'b0, sel_addr} < DEPTH_L);
  assign cap_data  = pend_err ? '0 : ram_rdata;

  always_comb begin
    state_n     = state;
    rr_last_n   = rr_last;
    pend_id_n   = pend_id;
    pend_we_n   = pend_we;
    pend_err_n  = pend_err;
    gnt0_n      = 1'b0;
    gnt1_n      = 1'b0;
    rvalid0_n   = 1'b0;
    rvalid1_n   = 1'b0;
    err0_n      = 1'b0;
    err1_n      = 1'b0;
    ram_en_n    = 1'b0;
    ram_addr_n  = ram_addr;
    ram_wdata_n = ram_wdata;
    rdata0_n    = rdata0;
    rdata1_n    = rdata1;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          ram_addr_n  = sel_addr;
          ram_wdata_n = sel_wdata;
          ram_en_n    = sel_we & in_range;
          gnt0_n      = ~winner;
          gnt1_n      = winner;
          err0_n      = ~winner & ~in_range;
          err1_n      = winner & ~in_range;
          rr_last_n   = winner;
          pend_id_n   = winner;
          pend_we_n   = sel_we;
          pend_err_n  = ~in_range;
          state_n     = ACCESS;
        end
      end
      ACCESS: begin
        state_n = pend_we ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        if (pend_id) begin
          rdata1_n  = cap_data;
          rvalid1_n = 1'b1;
        end else begin
          rdata0_n  = cap_data;
          rvalid0_n = 1'b1;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      pend_id   <= 1'b0;
      pend_we   <= 1'b0;
      pend_err  <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state     <= state_n;
      rr_last   <= rr_last_n;
      pend_id   <= pend_id_n;
      pend_we   <= pend_we_n;
      pend_err  <= pend_err_n;
      gnt0      <= gnt0_n;
      gnt1      <= gnt1_n;
      rvalid0   <= rvalid0_n;
      rvalid1   <= rvalid1_n;
      err0      <= err0_n;
      err1      <= err1_n;
      ram_en    <= ram_en_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
      rdata0    <= rdata0_n;
      rdata1    <= rdata1_n;
    end
  end

  assign dbg.state   = state;
  assign dbg.rr_last = rr_last;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural 1024x16 RAM with registered read port,
// table of single-requester transactions, then hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic        ram_en;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  dbg_t        dbg;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [1024];
  logic [15:0] exp_rd [2];
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];

  typedef struct {
    logic        id;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } txn_t;

  txn_t vecs [11];

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .err0      (err0),
    .err1      (err1),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .dbg       (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM port B: address truncated to 10 bits, registered read
  always @(posedge clk) begin
    if (ram_en) mem[ram_addr[9:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic id, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
    if (id) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  // single transaction from IDLE; drive at negedge, sample at negedge
  task automatic do_txn(input txn_t t);
    logic g, og, e, rv, orv;
    logic [15:0] rd, ord;
    set_req(t.id, 1'b1, t.we, t.addr, t.wdata);
    @(negedge clk);
    g  = t.id ? gnt1 : gnt0;
    og = t.id ? gnt0 : gnt1;
    e  = t.id ? err1 : err0;
    check("txn_gnt", 32'(g), 32'd1);
    check("txn_gnt_other", 32'(og), 32'd0);
    check("txn_err", 32'(e), 32'(t.exp_err));
    check("txn_ram_en", 32'(ram_en), 32'(t.we && !t.exp_err));
    check("txn_ram_addr", 32'(ram_addr), 32'(t.addr));
    check("txn_state_access", 32'(dbg.state), 32'(ACCESS));
    if (t.we) check("txn_ram_wdata", 32'(ram_wdata), 32'(t.wdata));
    set_req(t.id, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("txn_ram_en_off", 32'(ram_en), 32'd0);
    check("txn_pulses_off", 32'(gnt0 | gnt1 | err0 | err1), 32'd0);
    check("txn_no_early_rvalid", 32'(rvalid0 | rvalid1), 32'd0);
    if (!t.we) begin
      @(negedge clk);
      rv  = t.id ? rvalid1 : rvalid0;
      orv = t.id ? rvalid0 : rvalid1;
      rd  = t.id ? rdata1 : rdata0;
      ord = t.id ? rdata0 : rdata1;
      exp_rd[t.id] = t.exp_rdata;
      check("txn_rvalid", 32'(rv), 32'd1);
      check("txn_rvalid_other", 32'(orv), 32'd0);
      check("txn_rdata", 32'(rd), 32'(t.exp_rdata));
      check("txn_rdata_other_held", 32'(ord), 32'(exp_rd[~t.id]));
    end
    check("txn_back_idle", 32'(dbg.state), 32'(IDLE));
  endtask

  initial begin
    int n_gnt;
    int prev_cyc;
    logic [15:0] pv;

    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    exp_rd[0] = 16'h0;
    exp_rd[1] = 16'h0;

    //             id    we    addr      wdata     err   rdata
    vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b1, 1'b1, 16'h0000, 16'h5A5A, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 16'h03FF, 16'h0F0F, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 16'h03FF, 16'h0000, 1'b0, 16'h0F0F};
    vecs[5]  = '{1'b0, 1'b1, 16'h0400, 16'h1234, 1'b1, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 16'h0400, 16'h0000, 1'b1, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h5A5A};
    vecs[8]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 1'b1, 16'h0021, 16'h2222, 1'b0, 16'h0000};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_pulses", 32'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_en}), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(IDLE));
    check("rst_rr_last", 32'(dbg.rr_last), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) do_txn(vecs[i]);

    // both requesters hold reads: strict alternation, 3 cycles per access
    set_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
    set_req(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0);
    n_gnt = 0;
    prev_cyc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (n_gnt == 6 && exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(negedge clk);
      check("alt_gnt_rvalid_overlap", 32'((gnt0 & rvalid0) | (gnt1 & rvalid1)), 32'd0);
      check("alt_rvalid0_expected", 32'(rvalid0 && exp_q0.size() == 0), 32'd0);
      check("alt_rvalid1_expected", 32'(rvalid1 && exp_q1.size() == 0), 32'd0);
      if (rvalid0 && exp_q0.size() > 0) begin
        pv = exp_q0.pop_front();
        check("alt_rdata0", 32'(rdata0), 32'(pv));
      end
      if (rvalid1 && exp_q1.size() > 0) begin
        pv = exp_q1.pop_front();
        check("alt_rdata1", 32'(rdata1), 32'(pv));
      end
      if (gnt0 || gnt1) begin
        check("alt_single_gnt", 32'(gnt0 & gnt1), 32'd0);
        check("alt_order", 32'(gnt1), 32'(n_gnt % 2));
        if (n_gnt > 0) check("alt_spacing", 32'(cyc - prev_cyc), 32'd3);
        prev_cyc = cyc;
        if (gnt1) exp_q1.push_back(16'h2222);
        else      exp_q0.push_back(16'h1111);
        n_gnt++;
        if (n_gnt == 6) begin
          set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
          set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        end
      end
    end
    check("alt_grant_count", 32'(n_gnt), 32'd6);
    check("alt_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);

    // reset during ACCESS of a req1 read discards it
    set_req(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0);
    @(negedge clk);
    check("rstmid_gnt1", 32'(gnt1), 32'd1);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_state", 32'(dbg.state), 32'(IDLE));
    check("rstmid_pulses", 32'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_en}), 32'd0);
    check("rstmid_rr_last", 32'(dbg.rr_last), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_no_rvalid1", 32'(rvalid1), 32'd0);
    end
    exp_rd[0] = 16'h0;
    exp_rd[1] = 16'h0;
    set_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
    set_req(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0);
    @(negedge clk);
    check("rstmid_tie_gnt0", 32'({gnt0, gnt1}), 32'b10);
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    check("rstmid_rvalid0", 32'(rvalid0), 32'd1);
    check("rstmid_rdata0", 32'(rdata0), 32'h1111);
    check("rstmid_rdata1_cleared", 32'(rdata1), 32'(exp_rd[1]));

    // lone held writer: gnt0 every 2 cycles, then req1 wins the next tie
    set_req(1'b0, 1'b1, 1'b1, 16'h0030, 16'h7777);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("held_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      check("held_ram_en", 32'(ram_en), 32'(i % 2 == 0));
      check("held_gnt1", 32'(gnt1), 32'd0);
    end
    check("held_rr_last", 32'(dbg.rr_last), 32'd0);
    set_req(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0);
    @(negedge clk);
    check("held_tie_gnt1", 32'({gnt0, gnt1}), 32'b01);
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    check("held_rvalid1", 32'(rvalid1), 32'd1);
    check("held_rdata1", 32'(rdata1), 32'h7777);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares port B of the dual-port block RAM (1024 x 16-bit words) between two requesters.
  - Requester 0: CPU load/store unit.
  - Requester 1: I/O / DMA engine.
- Port A stays dedicated to instruction fetch and is not touched by this block.
- Grants one access at a time using round-robin priority and returns read data with a one-cycle valid pulse.
- Sits between the datapath/IO blocks and the RAM's B-side enable/address/data/out signals.

Parameters:
- DATA_W, 16, word width.
- ADDR_W, 16, address width.
- DEPTH, 1024, number of implemented RAM words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, requester 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read; must be held stable while req is high.
- addr0 / addr1  in  ADDR_W  word address; held stable while req is high.
- wdata0 / wdata1  in  DATA_W  write data; held stable while req is high.
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted; requester may drop or change req next cycle.
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdataN holds read result.
- rdata0 / rdata1  out  DATA_W  registered read data, held until next rvalid to that requester.
- err0 / err1  out  1  one-cycle pulse alongside gnt: address out of range.
- ram_en  out  1  write enable to RAM port B (1 = write).
- ram_addr  out  ADDR_W  address to RAM port B.
- ram_wdata  out  DATA_W  write data to RAM port B.
- ram_rdata  in  DATA_W  registered output of RAM port B.

Behaviour:
- All outputs are registered. Reset values: gnt*, rvalid*, err*, ram_en = 0; ram_addr, ram_wdata, rdata* = 0; state = IDLE; rr_last = 1, so requester 0 wins the first tie.
- State machine with states IDLE, ACCESS, CAPTURE:
  - IDLE:
    - With no req, stay in IDLE; ram_en = 0.
    - With only one req high, that requester wins.
    - With both high, the winner is the requester that is not rr_last.
    - At the edge, latch ram_addr = addrW and ram_wdata = wdataW.
    - ram_en = weW, but only if addrW < DEPTH; otherwise 0.
    - Pulse gntW, and errW if out of range.
    - Record winner in rr_last and op kind in a pending flag; go to ACCESS.
  - ACCESS:
    - RAM samples address/write this cycle.
    - At the edge, ram_en returns to 0.
    - Write: go to IDLE.
    - Read: go to CAPTURE.
  - CAPTURE:
    - ram_rdata is valid this cycle.
    - At the edge, rdataW = ram_rdata (or 16'h0000 if the access was out of range), pulse rvalidW, go to IDLE.
- Latency, with req first sampled at edge T:
  - gnt is high in cycle T+1.
  - A write lands in RAM at edge T+1.
  - rvalid/rdata are high/valid in cycle T+3.
- Throughput:
  - A read occupies 3 cycles (IDLE, ACCESS, CAPTURE).
  - A write occupies 2 cycles.
  - Requests are not sampled outside IDLE.
- Fairness:
  - With both requesters continuously requesting, grants strictly alternate.
  - A lone requester is granted every time it returns to IDLE.
- Held requests: a requester still holding req after its gnt is treated as a new request, so held reqs produce repeat accesses.
- Out of range:
  - Writes are suppressed and RAM is unchanged.
  - Reads return 0 with a normal rvalid.
  - err pulses together with gnt.
- ram_addr is truncated to the low bits by the RAM; this block checks the full ADDR_W value against DEPTH.
- Reset mid-operation:
  - The next cycle is IDLE with all pulses 0.
  - A pending read is discarded; no rvalid is issued.
  - A write already in ACCESS may have been committed by the RAM; no guarantee either way.
- Simultaneous events: a gnt to one requester never coincides with rvalid to the same requester, because rvalid always comes 2 cycles after gnt.

Decomposition:
- Shared package mem_pkg holds:
  - constants DATA_W, ADDR_W, MEM_DEPTH;
  - state enum {IDLE, ACCESS, CAPTURE};
  - requester ID typedef (1-bit).
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter (inputs req0/req1/last; outputs winner/valid).
- The FSM and datapath registers stay in mem_port_arbiter.

Test Plan:
- Reset, then req0 = 1, we0 = 1, addr0 = 16'h0010, wdata0 = 16'hBEEF -> gnt0 in cycle T+1; ram_en = 1 with ram_addr = 16'h0010 for exactly one cycle; no rvalid.
- After a write of BEEF to 16'h0010, req1 read of addr 16'h0010 -> gnt1 at T+1, rvalid1 at T+3, rdata1 = 16'hBEEF; rdata0 unchanged.
- req0 and req1 both held high with reads for 6 grants -> grant order 0,1,0,1,0,1; each rvalid goes to the matching requester; 3 cycles per access.
- req0 write to addr 16'h0400 (1024) with data 16'h1234 -> gnt0 and err0 pulse together; ram_en stays 0; a follow-up read of 16'h0400 -> rdata0 = 0, err0 = 1.
- req1 read granted, reset asserted in the ACCESS cycle -> the next cycle is IDLE; rvalid1 never pulses; the next req0 wins the first arbitration.
- req0 held continuously with writes, req1 idle -> gnt0 every 2 cycles; rr_last stays 0 without starving a later req1, which is granted at the next IDLE.
